// File: rtl/hs_fork_tx.sv
// hs_fork_tx
// ----------
// Clocked 4-phase handshake transmitter. One token from the synchronous
// producer is broadcast on out_data_o with a single shared request req_o to
// OUT_NUM consumers. Their acknowledges are joined with C-element semantics:
// the block only moves when every acknowledge agrees (all high or all low).
//
// Ports
//   clk_i        system clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   producer offers in_data_i
//   in_ready_o   block can take a token (transfer when valid && ready)
//   in_data_i    token from the producer
//   req_o        registered 4-phase request to all consumers
//   out_data_o   registered bundled data, stable while req_o is in flight
//   ack_i        per-consumer acknowledge, asynchronous to clk_i
//   busy_o       high in every state except IDLE
//   tok_cnt_o    count of completed 4-phase cycles (wraps)
//   err_o        sticky flag: an acknowledge was seen high while idle
//
// Configuration macro
//   HS_FORK_ACK_SYNC_EN  when defined, each ack bit goes through a 2-flop
//                        synchronizer (sampling latency 2 cycles). When not
//                        defined the acks are used combinationally and must
//                        come from the clk_i domain.

module hs_fork_tx #(
  parameter int OUT_NUM = 2,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               req_o,
  output logic [DATA_W-1:0]  out_data_o,
  input  logic [OUT_NUM-1:0] ack_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   tok_cnt_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    DRAIN  = 2'd0,
    IDLE   = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_e;

  state_e              state_q;
  logic                req_q;
  logic [DATA_W-1:0]   outData_q;
  logic [CNT_W-1:0]    tokCnt_q;
  logic                err_q;

  logic [OUT_NUM-1:0]  ackSampled;
  logic                sampleValid;
  logic                aHi;
  logic                aLo;

`ifdef HS_FORK_ACK_SYNC_EN
  logic [OUT_NUM-1:0]  ackMeta_q;
  logic [OUT_NUM-1:0]  ackSync_q;
  logic [1:0]          syncFill_q;

  // Two-flop synchronizer per ack bit. syncFill_q tracks how many edges have
  // passed since reset so DRAIN does not trust the reset-zero contents of the
  // synchronizer; otherwise a consumer still holding ack high across a reset
  // would look idle and the FSM would leave DRAIN too early.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ackMeta_q  <= '0;
      ackSync_q  <= '0;
      syncFill_q <= '0;
    end else begin
      ackMeta_q  <= ack_i;
      ackSync_q  <= ackMeta_q;
      syncFill_q <= {syncFill_q[0], 1'b1};
    end
  end

  assign ackSampled  = ackSync_q;
  assign sampleValid = syncFill_q[1];
`else
  assign ackSampled  = ack_i;
  assign sampleValid = 1'b1;
`endif

  // C-element style join: all acks high or all acks low.
  assign aHi = &ackSampled;
  assign aLo = ~|ackSampled;

  // Main handshake FSM with registered req, data, counter and error flag.
  // out_data only loads on an accepted transfer, which keeps the bundled data
  // stable for the whole 4-phase cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DRAIN;
      req_q     <= 1'b0;
      outData_q <= '0;
      tokCnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        DRAIN: begin
          req_q <= 1'b0;
          if (sampleValid && aLo) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (!aLo) begin
            err_q <= 1'b1;
          end
          if (in_valid_i) begin
            outData_q <= in_data_i;
            req_q     <= 1'b1;
            state_q   <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (aHi) begin
            req_q   <= 1'b0;
            state_q <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (aLo) begin
            tokCnt_q <= tokCnt_q + CNT_W'(1);
            state_q  <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= DRAIN;
        end
      endcase
    end
  end

  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign req_o      = req_q;
  assign out_data_o = outData_q;
  assign tok_cnt_o  = tokCnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_hs_fork_tx.sv
// Testbench for hs_fork_tx with three consumers. The expected behaviour is
// kept as a handful of facts: number of completed tokens, whether an ack was
// ever seen while idle, the ack sampling latency S and the list of tokens
// sent. A narrow counter keeps the wrap scenario short.

module tb_hs_fork_tx;

  localparam int OUT_NUM = 3;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
`ifdef HS_FORK_ACK_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               req;
  logic [DATA_W-1:0]  out_data;
  logic [OUT_NUM-1:0] ack;
  logic               busy;
  logic [CNT_W-1:0]   tok_cnt;
  logic               err;

  int testsRun    = 0;
  int testsFailed = 0;
  int completed   = 0;
  logic expErr    = 1'b0;

  hs_fork_tx #(
    .OUT_NUM(OUT_NUM),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .req_o      (req),
    .out_data_o (out_data),
    .ack_i      (ack),
    .busy_o     (busy),
    .tok_cnt_o  (tok_cnt),
    .err_o      (err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock edge, then settle 1 unit so both driving and sampling
  // happen away from the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] expTok();
    return CNT_W'(completed % (1 << CNT_W));
  endfunction

  // Reset with acks low: in_ready must rise exactly S+1 edges after release.
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ack = '0;
    repeat (3) tick();
    testsRun++; if (req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req: got %0b expected 0", req); end
    testsRun++; if (out_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_data: got %0h expected 0", out_data); end
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %0b expected 0", in_ready); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 1", busy); end
    testsRun++; if (tok_cnt !== '0) begin testsFailed++; $display("[TB] FAIL reset_tok: got %0h expected 0", tok_cnt); end
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
    rst = 1'b0; completed = 0; expErr = 1'b0;
    for (int k = 0; k <= S; k++) begin
      tick();
      testsRun++; if (in_ready !== (k == S)) begin testsFailed++; $display("[TB] FAIL reset_release_ready k=%0d: got %0b expected %0b", k, in_ready, (k == S)); end
      testsRun++; if (req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_release_req: got %0b expected 0", req); end
    end
    testsRun++; if (tok_cnt !== expTok()) begin testsFailed++; $display("[TB] FAIL reset_release_tok: got %0h expected %0h", tok_cnt, expTok()); end
    testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL reset_release_err: got %0b expected %0b", err, expErr); end
  endtask

  // One token 0xA5, acks rising one by one with random gaps.
  task automatic test_single();
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    testsRun++; if (req !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_req_rise: got %0b expected 1", req); end
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_ready_low: got %0b expected 0", in_ready); end
    for (int i = 0; i < OUT_NUM; i++) begin
      repeat ($urandom_range(1, 3)) begin
        tick();
        testsRun++; if (req !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_req_hold: got %0b expected 1", req); end
        testsRun++; if (out_data !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single_data_hold: got %0h expected a5", out_data); end
      end
      ack[i] = 1'b1;
    end
    for (int k = 0; k <= S; k++) begin
      tick();
      testsRun++; if (req !== (k < S)) begin testsFailed++; $display("[TB] FAIL single_req_fall k=%0d: got %0b expected %0b", k, req, (k < S)); end
      testsRun++; if (out_data !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single_data_ack: got %0h expected a5", out_data); end
    end
    ack = '0;
    for (int k = 0; k <= S; k++) begin
      tick();
      if (k == S) completed++;
      testsRun++; if (in_ready !== (k == S)) begin testsFailed++; $display("[TB] FAIL single_idle k=%0d: got %0b expected %0b", k, in_ready, (k == S)); end
      testsRun++; if (tok_cnt !== expTok()) begin testsFailed++; $display("[TB] FAIL single_tok k=%0d: got %0h expected %0h", k, tok_cnt, expTok()); end
      testsRun++; if (out_data !== 8'hA5) begin testsFailed++; $display("[TB] FAIL single_data_release: got %0h expected a5", out_data); end
    end
  endtask

  // Partial acknowledge held for 50 cycles must not release req.
  task automatic test_partial_ack();
    logic [DATA_W-1:0] d;
    int n;
    d = DATA_W'($urandom);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ack = 3'b011;
    repeat (50) begin
      tick();
      testsRun++; if (req !== 1'b1) begin testsFailed++; $display("[TB] FAIL partial_req: got %0b expected 1", req); end
      testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL partial_ready: got %0b expected 0", in_ready); end
      testsRun++; if (out_data !== d) begin testsFailed++; $display("[TB] FAIL partial_data: got %0h expected %0h", out_data, d); end
    end
    ack = 3'b111;
    n = 0;
    while (req === 1'b1 && n < S + 4) begin tick(); n++; end
    testsRun++; if (n !== S + 1) begin testsFailed++; $display("[TB] FAIL partial_release_latency: got %0d cycles expected %0d", n, S + 1); end
    ack = '0;
    repeat (S + 1) tick();
    completed++;
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL partial_idle: got %0b expected 1", in_ready); end
    testsRun++; if (tok_cnt !== expTok()) begin testsFailed++; $display("[TB] FAIL partial_tok: got %0h expected %0h", tok_cnt, expTok()); end
  endtask

  // Tokens 0x01..0x04 streamed with in_valid held; consumers echo req one
  // cycle late. Every req rise must present the oldest undelivered token.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] sent[$];
    logic [DATA_W-1:0] expData;
    int   sentCnt   = 0;
    int   delivered = 0;
    int   cyc       = 0;
    logic reqPrev   = 1'b0;
    logic ackDelay  = 1'b0;
    logic xfer;
    in_data = 8'h01; in_valid = 1'b1;
    while (cyc < 300 && !(delivered == 4 && in_ready === 1'b1 && sent.size() == 0)) begin
      xfer = in_valid && in_ready;
      if (xfer) sent.push_back(in_data);
      tick();
      cyc++;
      if (xfer) begin
        sentCnt++;
        if (sentCnt < 4) in_data = DATA_W'(sentCnt + 1);
        else in_valid = 1'b0;
      end
      if (req === 1'b1 && reqPrev === 1'b0) begin
        expData = (sent.size() > 0) ? sent.pop_front() : 'x;
        testsRun++; if (out_data !== expData) begin testsFailed++; $display("[TB] FAIL b2b_data #%0d: got %0h expected %0h", delivered, out_data, expData); end
        delivered++;
      end
      ack = {OUT_NUM{ackDelay}};
      ackDelay = req;
      reqPrev = req;
    end
    in_valid = 1'b0;
    completed += 4;
    testsRun++; if (delivered !== 4) begin testsFailed++; $display("[TB] FAIL b2b_count: got %0d expected 4", delivered); end
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_idle: got %0b expected 1", in_ready); end
    testsRun++; if (tok_cnt !== expTok()) begin testsFailed++; $display("[TB] FAIL b2b_tok: got %0h expected %0h", tok_cnt, expTok()); end
    testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL b2b_err: got %0b expected %0b", err, expErr); end
  endtask

  // Reset while req is high and all consumers hold ack high: the block must
  // stay in DRAIN until the acks drop and must not flag an error.
  task automatic test_mid_reset();
    in_data = DATA_W'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ack = '1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; completed = 0; expErr = 1'b0;
    testsRun++; if (out_data !== '0) begin testsFailed++; $display("[TB] FAIL midrst_data: got %0h expected 0", out_data); end
    repeat (10) begin
      tick();
      testsRun++; if (req !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_req: got %0b expected 0", req); end
      testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_ready: got %0b expected 0", in_ready); end
      testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_busy: got %0b expected 1", busy); end
    end
    ack = '0;
    for (int k = 0; k <= S; k++) begin
      tick();
      testsRun++; if (in_ready !== (k == S)) begin testsFailed++; $display("[TB] FAIL midrst_idle k=%0d: got %0b expected %0b", k, in_ready, (k == S)); end
    end
    testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL midrst_err: got %0b expected %0b", err, expErr); end
    testsRun++; if (tok_cnt !== expTok()) begin testsFailed++; $display("[TB] FAIL midrst_tok: got %0h expected %0h", tok_cnt, expTok()); end
  endtask

  // Full handshake for one random token with consumers answering at once.
  task automatic send_token();
    logic [DATA_W-1:0] d;
    int n;
    d = DATA_W'($urandom);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    testsRun++; if (out_data !== d || req !== 1'b1) begin testsFailed++; $display("[TB] FAIL tok_launch: got req=%0b data=%0h expected req=1 data=%0h", req, out_data, d); end
    ack = '1;
    n = 0;
    while (req !== 1'b0 && n < S + 4) begin tick(); n++; end
    ack = '0;
    n = 0;
    while (in_ready !== 1'b1 && n < S + 4) begin tick(); n++; end
    completed++;
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL tok_return: got in_ready=%0b expected 1", in_ready); end
    testsRun++; if (tok_cnt !== expTok()) begin testsFailed++; $display("[TB] FAIL tok_count: got %0h expected %0h", tok_cnt, expTok()); end
  endtask

  // Ack seen while idle sets the sticky error; then run the counter to its
  // maximum and across the wrap.
  task automatic test_error_wrap();
    ack = 3'b001;
    for (int k = 0; k <= S; k++) tick();
    expErr = 1'b1;
    testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL err_set: got %0b expected %0b", err, expErr); end
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_stay_idle: got %0b expected 1", in_ready); end
    ack = '0;
    repeat (S + 1) tick();
    while (completed < (1 << CNT_W) - 1) send_token();
    testsRun++; if (tok_cnt !== {CNT_W{1'b1}}) begin testsFailed++; $display("[TB] FAIL wrap_max: got %0h expected %0h", tok_cnt, {CNT_W{1'b1}}); end
    testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL err_sticky: got %0b expected %0b", err, expErr); end
    send_token();
    testsRun++; if (tok_cnt !== '0) begin testsFailed++; $display("[TB] FAIL wrap_zero: got %0h expected 0", tok_cnt); end
    testsRun++; if (err !== expErr) begin testsFailed++; $display("[TB] FAIL err_sticky_wrap: got %0b expected %0b", err, expErr); end
  endtask

  // Scenario sequence and summary.
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ack = '0;
    test_reset();
    test_single();
    test_partial_ack();
    test_back_to_back();
    test_mid_reset();
    test_error_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
